// File: rtl/bp_io_stream_arbiter.sv
// bp_io_stream_arbiter: round-robin arbiter merging num_req_p packed 32-bit
// request streams into one output stream through a single-word register.
// The output register accepts a new word every cycle while the sink is ready.
// Optional feature macro: BP_IO_ARB_WATCHDOG_EN adds a sticky stall watchdog
// that flags when the sink has refused a held word for timeout_p cycles.
module bp_io_stream_arbiter #(
  parameter int num_req_p = 2,
  parameter int timeout_p = 1024,
  localparam int lg_num_req_lp = (num_req_p > 2) ? $clog2(num_req_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [32*num_req_p-1:0]   data_i,
  input  logic [num_req_p-1:0]      v_i,
  output logic [num_req_p-1:0]      ready_and_o,
  output logic [31:0]               data_o,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [lg_num_req_lp-1:0]  src_id_o,
  output logic                      stall_err_o
);

  typedef enum logic {e_empty, e_full} state_e;

  localparam logic [lg_num_req_lp-1:0] last_idx_lp = lg_num_req_lp'(num_req_p - 1);

  state_e                   state_r, state_n;
  logic [lg_num_req_lp-1:0] rr_ptr_r, rr_next;
  logic [lg_num_req_lp-1:0] win_hi, win_lo, winner;
  logic [31:0]              word_hi, word_lo, win_word;
  logic                     found_hi;
  logic                     accept, any_v, in_xfer, out_xfer;
  logic [31:0]              data_p1;
  logic [lg_num_req_lp-1:0] src_p1;

  // Round-robin search: first valid at or above rr_ptr_r, else first valid below it
  always_comb begin
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    word_hi  = '0;
    word_lo  = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (v_i[i] && (i >= int'(rr_ptr_r))) begin
        found_hi = 1'b1;
        win_hi   = lg_num_req_lp'(i);
        word_hi  = data_i[32*i +: 32];
      end
      if (v_i[i] && (i < int'(rr_ptr_r))) begin
        win_lo  = lg_num_req_lp'(i);
        word_lo = data_i[32*i +: 32];
      end
    end
    winner   = found_hi ? win_hi : win_lo;
    win_word = found_hi ? word_hi : word_lo;
  end

  assign accept   = (state_r == e_empty) | ready_and_i;
  assign any_v    = |v_i;
  assign in_xfer  = accept & any_v & ~reset_i;
  assign out_xfer = v_o & ready_and_i;
  assign rr_next  = (winner == last_idx_lp) ? '0 : winner + 1'b1;

  // Grant is a pure function of valids, state, pointer and sink ready (never data)
  assign ready_and_o = in_xfer ? ({{(num_req_p-1){1'b0}}, 1'b1} << winner) : '0;

  // Next-state logic for the one-word output register
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_empty: if (in_xfer) state_n = e_full;
      e_full:  if (out_xfer && !in_xfer) state_n = e_empty;
      default: state_n = e_empty;
    endcase
  end

  // State register and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_empty;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_n;
      if (in_xfer) rr_ptr_r <= rr_next;
    end
  end

  // Output word register: loads the winner's word on every input transfer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_p1 <= '0;
      src_p1  <= '0;
    end else if (in_xfer) begin
      data_p1 <= win_word;
      src_p1  <= winner;
    end
  end

  assign v_o      = (state_r == e_full);
  assign data_o   = data_p1;
  assign src_id_o = src_p1;

`ifdef BP_IO_ARB_WATCHDOG_EN
  localparam int cnt_w_lp = $clog2(timeout_p + 1);

  logic [cnt_w_lp-1:0] stall_cnt_r;
  logic                stall_err_r;
  logic                stalled;

  assign stalled = v_o & ~ready_and_i;

  // Stall watchdog: counts consecutive refused cycles, saturates, error is sticky
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_r <= '0;
      stall_err_r <= 1'b0;
    end else if (stalled) begin
      if (stall_cnt_r != cnt_w_lp'(timeout_p)) stall_cnt_r <= stall_cnt_r + 1'b1;
      if (stall_cnt_r == cnt_w_lp'(timeout_p - 1)) stall_err_r <= 1'b1;
    end else begin
      stall_cnt_r <= '0;
    end
  end

  assign stall_err_o = stall_err_r;
`else
  assign stall_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_io_stream_arbiter.sv
// Directed bench for bp_io_stream_arbiter: a 2-requester instance with a short
// watchdog threshold and a 3-requester instance for pointer wrap-around.
module tb_bp_io_stream_arbiter;

`ifdef BP_IO_ARB_WATCHDOG_EN
  localparam bit wd_lp = 1'b1;
`else
  localparam bit wd_lp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] data_i;
  logic [1:0]  v_i;
  logic [1:0]  ready_and_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_and_i;
  logic [0:0]  src_id_o;
  logic        stall_err_o;

  logic [95:0] data3;
  logic [2:0]  v3;
  logic [2:0]  ready3;
  logic [31:0] data_o3;
  logic        v_o3;
  logic        ready_in3;
  logic [1:0]  src3;
  logic        err3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_io_stream_arbiter #(.num_req_p(2), .timeout_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i),
    .ready_and_o(ready_and_o), .data_o(data_o), .v_o(v_o),
    .ready_and_i(ready_and_i), .src_id_o(src_id_o), .stall_err_o(stall_err_o)
  );

  bp_io_stream_arbiter #(.num_req_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data3), .v_i(v3),
    .ready_and_o(ready3), .data_o(data_o3), .v_o(v_o3),
    .ready_and_i(ready_in3), .src_id_o(src3), .stall_err_o(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 2'b11; ready_and_i = 1'b1;
    data_i = {32'h8000_0B11, 32'h8000_1241};
    data3 = '0; v3 = 3'b000; ready_in3 = 1'b1;
    tick(); tick();
    // reset state, ready held low despite valids
    chk("rst_v_o", 32'(v_o), 32'd0);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_src", 32'(src_id_o), 32'd0);
    chk("rst_ready", 32'(ready_and_o), 32'd0);
    chk("rst_err", 32'(stall_err_o), 32'd0);

    // single requester
    reset_i = 1'b0; v_i = 2'b00;
    tick();
    v_i = 2'b01;
    #1;
    chk("single_ready", 32'(ready_and_o), 32'b01);
    tick();
    v_i = 2'b00;
    chk("single_v_o", 32'(v_o), 32'd1);
    chk("single_data", data_o, 32'h8000_1241);
    chk("single_src", 32'(src_id_o), 32'd0);
    tick();
    chk("single_drain", 32'(v_o), 32'd0);

    // round-robin fairness from a fresh pointer
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    data_i = {32'h8000_0B11, 32'h0000_0A00};
    v_i = 2'b11; ready_and_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_v_o_%0d", k), 32'(v_o), 32'd1);
      chk($sformatf("rr_src_%0d", k), 32'(src_id_o), 32'(k % 2));
      chk($sformatf("rr_data_%0d", k), data_o, (k % 2 == 1) ? 32'h8000_0B11 : 32'h0000_0A00);
    end

    // backpressure: word from requester 1 held, pointer back at 0
    v_i = 2'b10; ready_and_i = 1'b0;
    data_i = {32'h0000_3333, 32'h0000_0A00};
    #1;
    chk("bp_ready0", 32'(ready_and_o), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("bp_ready_%0d", k), 32'(ready_and_o), 32'd0);
      chk($sformatf("bp_v_o_%0d", k), 32'(v_o), 32'd1);
      chk($sformatf("bp_data_%0d", k), data_o, 32'h8000_0B11);
      chk($sformatf("bp_src_%0d", k), 32'(src_id_o), 32'd1);
      chk($sformatf("wd_err_%0d", k), 32'(stall_err_o), 32'(wd_lp && (k >= 4)));
    end
    ready_and_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_and_o), 32'b10);
    tick();
    v_i = 2'b00;
    chk("bp_next_v_o", 32'(v_o), 32'd1);
    chk("bp_next_data", data_o, 32'h0000_3333);
    chk("bp_next_src", 32'(src_id_o), 32'd1);
    tick();
    chk("bp_drain", 32'(v_o), 32'd0);
    chk("wd_sticky", 32'(stall_err_o), 32'(wd_lp));

    // reset mid-operation with a held word and pointer at 1
    data_i = {32'h8000_0B11, 32'h8000_1241};
    v_i = 2'b01; ready_and_i = 1'b0;
    tick();
    chk("mid_full", 32'(v_o), 32'd1);
    reset_i = 1'b1; v_i = 2'b11;
    #1;
    chk("mid_rst_ready", 32'(ready_and_o), 32'd0);
    tick();
    reset_i = 1'b0; ready_and_i = 1'b1;
    chk("mid_v_o", 32'(v_o), 32'd0);
    chk("mid_data", data_o, 32'h0);
    chk("mid_err", 32'(stall_err_o), 32'd0);
    #1;
    chk("mid_grant", 32'(ready_and_o), 32'b01);
    tick();
    v_i = 2'b00;
    chk("mid_src", 32'(src_id_o), 32'd0);
    chk("mid_word", data_o, 32'h8000_1241);

    // wrap with three requesters, pointer first moved to 1
    data3 = {32'h8000_0133, 32'h0000_0022, 32'h0000_0011};
    v3 = 3'b001;
    tick();
    chk("wrap_first_src", 32'(src3), 32'd0);
    v3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wrap_src_%0d", k), 32'(src3), (k % 2 == 0) ? 32'd2 : 32'd0);
      chk($sformatf("wrap_data_%0d", k), data_o3, (k % 2 == 0) ? 32'h8000_0133 : 32'h0000_0011);
    end
    v3 = 3'b000;
    chk("wrap_err", 32'(err3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_io_stream_arbiter.md
BP_IO_STREAM_ARBITER -- requirements
Module: bp_io_stream_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2, number of requesters sharing the packed I/O stream; legal range 2..8.
REQ-002 SHALL have parameter timeout_p, default 1024, the stall-watchdog threshold in cycles; legal range 2..65535.
REQ-003 SHALL derive localparam lg_num_req_lp = max(1, ceil(log2(num_req_p))).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_i  input  32*num_req_p  packed words, one per requester: slice i = bits [32i+31:32i]; each word is {write[31], addr[30:8], data[7:0]}.
REQ-007 SHALL have port v_i  input  num_req_p  per-requester valid.
REQ-008 SHALL have port ready_and_o  output  num_req_p  per-requester ready; a word transfers when v_i[i] & ready_and_o[i].
REQ-009 SHALL have port data_o  output  32  the arbitrated word.
REQ-010 SHALL have port v_o  output  1  output valid.
REQ-011 SHALL have port ready_and_i  input  1  sink ready; a word transfers when v_o & ready_and_i.
REQ-012 SHALL have port src_id_o  output  lg_num_req_lp  index of the requester that supplied data_o.
REQ-013 SHALL have port stall_err_o  output  1  sticky watchdog error flag.

Function
REQ-014 SHALL hold a one-word output register with FSM states e_empty and e_full; v_o = (state == e_full).
REQ-015 SHALL define accept = (state == e_empty) | ready_and_i; ready_and_o SHALL be one-hot at the winner when accept & |v_i, else all zero.
REQ-016 SHALL pick the winner round-robin: the first index with v_i set, searching from rr_ptr_r upward and wrapping modulo num_req_p.
REQ-017 SHALL, on an input transfer, load data_o/src_id_o from the winner on the next edge and set rr_ptr_r = (winner+1) mod num_req_p.
REQ-018 SHALL leave rr_ptr_r unchanged in cycles with no input transfer.
REQ-019 SHALL use these transitions: e_empty->e_full on input transfer; e_full->e_empty on output transfer with no input transfer; e_full stays e_full on a simultaneous output and input transfer (new word replaces old).
REQ-020 SHALL sustain one word per cycle when ready_and_i is held high, with latency exactly 1 cycle from input transfer to v_o.
REQ-021 SHALL keep data_o and src_id_o stable while v_o=1 and ready_and_i=0.
REQ-022 SHALL pass data words unmodified, with no reordering within a single requester.
REQ-023 SHALL NOT let ready_and_o depend on data_i; it depends on v_i, state, rr_ptr_r and ready_and_i only.

Reset
REQ-024 SHALL, while reset_i=1, force state to e_empty, rr_ptr_r to 0, data_o to 0, src_id_o to 0, the watchdog counter to 0 and stall_err_o to 0.
REQ-025 SHALL hold ready_and_o at 0 while reset_i=1.
REQ-026 SHALL discard a word held mid-operation when reset is asserted.

Configuration
REQ-027 SHALL, with BP_IO_ARB_WATCHDOG_EN defined, count the consecutive cycles with v_o=1 and ready_and_i=0, and clear the count on any output transfer.
REQ-028 SHALL, with BP_IO_ARB_WATCHDOG_EN defined, set stall_err_o on the edge where the count reaches timeout_p; stall_err_o then stays 1 until reset, and the counter saturates.
REQ-029 SHALL, with BP_IO_ARB_WATCHDOG_EN undefined, tie stall_err_o to 0 and instantiate no counter logic.

Verification
REQ-030 Single requester: num_req_p=2; v_i=2'b01; data_i[31:0]=32'h8000_1241; ready_and_i=1 -> next cycle v_o=1, data_o=32'h8000_1241, src_id_o=0.
REQ-031 Round-robin fairness: v_i=2'b11 held high with ready_and_i=1 for 6 cycles -> src_id_o sequence 0,1,0,1,0,1 with one word per cycle and no bubbles.
REQ-032 Backpressure: one word held in the register; ready_and_i=0 for 5 cycles while v_i=2'b10 -> ready_and_o=0, data_o/src_id_o unchanged; ready_and_i=1 -> word drains and the next word loads in the same cycle.
REQ-033 Reset mid-operation: state e_full, rr_ptr_r=1; assert reset_i for 1 cycle -> v_o=0, data_o=0, and the next simultaneous request v_i=2'b11 is granted to index 0.
REQ-034 Watchdog (macro defined, timeout_p=4): v_o=1 with ready_and_i=0 -> stall_err_o rises after exactly 4 stalled cycles and stays 1 after ready_and_i returns; with the macro undefined, stall_err_o stays 0 throughout.
REQ-035 Wrap: num_req_p=3 with v_i=3'b101 and rr_ptr_r=1 -> grant order 2,0,2,0.
